// File: rtl/deser_pkg.sv
// ----------------------------------------------------------------------------
// deser_pkg
// Shared types and default constants for the buffered deserializer.
//   state_t          : receive state machine encoding (IDLE, RECEIVING, PARITY)
//   DESER_WIDTH_DEF  : default word width in bits
//   DESER_DEPTH_DEF  : default output FIFO depth in words
// ----------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        PARITY    = 2'd2
    } state_t;

    localparam int DESER_WIDTH_DEF = 8;
    localparam int DESER_DEPTH_DEF = 4;

endpackage

// File: rtl/deserializer_buffered_if.sv
// ----------------------------------------------------------------------------
// deserializer_buffered_if
// Groups the serial input, the consumer handshake and the FIFO status
// signals of deserializer_buffered.
//   data_in, write_in : serial bit and its valid strobe (producer side)
//   ack_in            : consumer pops the FIFO head
//   data_out          : FIFO head word (0 when empty)
//   data_ready        : FIFO not empty
//   status_out        : word partially received
//   full, level       : FIFO occupancy
//   overflow          : sticky flag, a completed word was dropped
//   parity_err        : one-cycle pulse on parity mismatch
// Modports: master drives the inputs (link/consumer side), slave is the DUT.
// ----------------------------------------------------------------------------
interface deserializer_buffered_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();

    logic                       data_in;
    logic                       write_in;
    logic                       ack_in;
    logic [WIDTH-1:0]           data_out;
    logic                       data_ready;
    logic                       status_out;
    logic                       full;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       overflow;
    logic                       parity_err;

    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out, full, level, overflow, parity_err
    );

    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out, full, level, overflow, parity_err
    );

endinterface

// File: rtl/deser_fifo.sv
// ----------------------------------------------------------------------------
// deser_fifo
// Output word FIFO for the deserializer. DEPTH must be a power of 2 so the
// pointers wrap naturally.
//   clock_100k, reset_n : clock, asynchronous active-low reset
//   push, din           : write din at the tail (accepted if not full, or if
//                         a pop happens in the same cycle)
//   pop                 : remove the head (ignored when empty)
//   dout                : head word, 0 when empty
//   empty, full, level  : occupancy
// ----------------------------------------------------------------------------
module deser_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock_100k,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock_100k or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // Storage needs no reset: dout is masked while the FIFO is empty.
    always_ff @(posedge clock_100k) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/deserializer_buffered.sv
// ----------------------------------------------------------------------------
// deserializer_buffered
// Serial-to-parallel converter with a DEPTH-entry output FIFO. One bit is
// sampled per clock while write_in is high; every WIDTH bits form a word that
// is queued for the consumer.
//   clock_100k : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : deserializer_buffered_if.slave (serial input, consumer
//                handshake, FIFO status, overflow and parity flags)
// Parameters: WIDTH (>=2), DEPTH (power of 2, >=2), MSB_FIRST (1: first bit
// lands in data_out[WIDTH-1], 0: first bit lands in data_out[0]).
// Optional feature: define DESER_PARITY_EN to expect one even-parity bit
// after each word; mismatching words are dropped and flagged on parity_err.
// ----------------------------------------------------------------------------
module deserializer_buffered
    import deser_pkg::*;
#(
    parameter int WIDTH     = DESER_WIDTH_DEF,
    parameter int DEPTH     = DESER_DEPTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clock_100k,
    input  logic reset_n,
    deserializer_buffered_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH+1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             status_q;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] push_word;
    logic             push_req;
    logic             last_bit;
    logic             fifo_empty, fifo_full;
`ifdef DESER_PARITY_EN
    logic             perr_q, perr_d;
`endif

    assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.data_in}
                                : {bus.data_in, shreg_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH-1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        push_word = shifted;
`ifdef DESER_PARITY_EN
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.write_in) begin
                    shreg_d = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = RECEIVING;
                end
            end
            RECEIVING: begin
                if (bus.write_in) begin
                    shreg_d = shifted;
                    if (last_bit) begin
                        cnt_d = '0;
`ifdef DESER_PARITY_EN
                        state_d = PARITY;
`else
                        push_req = 1'b1;
                        state_d  = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef DESER_PARITY_EN
            PARITY: begin
                if (bus.write_in) begin
                    // Even parity: word XOR parity bit must be 0.
                    push_word = shreg_q;
                    if (^{shreg_q, bus.data_in}) perr_d   = 1'b1;
                    else                         push_req = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO only drops the word when no pop frees a slot this cycle.
    assign overflow_d = overflow_q | (push_req & fifo_full & ~bus.ack_in);

    always_ff @(posedge clock_100k or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            status_q   <= 1'b0;
            overflow_q <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            status_q   <= (state_d != IDLE);
            overflow_q <= overflow_d;
`ifdef DESER_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    deser_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_100k (clock_100k),
        .reset_n    (reset_n),
        .push       (push_req),
        .pop        (bus.ack_in),
        .din        (push_word),
        .dout       (bus.data_out),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .level      (bus.level)
    );

    assign bus.data_ready = ~fifo_empty;
    assign bus.full       = fifo_full;
    assign bus.status_out = status_q;
    assign bus.overflow   = overflow_q;
`ifdef DESER_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/deserializer_buffered.md
# deserializer_buffered

Parametrised next-generation serial-to-parallel converter. It samples one bit per `clock_100k` cycle while `write_in` is high and assembles `WIDTH`-bit words in a selectable bit order. It queues completed words in a `DEPTH`-entry output FIFO, so the producer can keep streaming while the consumer acknowledges earlier words. It sits between the serial link front end and the word-oriented consumer queue.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal values are ≥ 2.
- `DEPTH`, 4: number of output FIFO entries; must be a power of 2 and ≥ 2.
- `MSB_FIRST`, 1: bit order.
  - 1: the first received bit lands in `data_out[WIDTH-1]` (shift left).
  - 0: the first received bit lands in `data_out[0]` (shift right).

Ports (one clock; reset is asynchronous and active-low):
- `clock_100k` in 1: sole clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `data_in` in 1: serial bit, sampled when `write_in`=1.
- `write_in` in 1: marks `data_in` as valid this cycle.
- `ack_in` in 1: consumer pops the FIFO head; ignored when `data_ready`=0.
- `data_out` out WIDTH: FIFO head word; reads 0 when the FIFO is empty.
- `data_ready` out 1: FIFO not empty.
- `status_out` out 1: a word is partially received (state RECEIVING or PARITY).
- `full` out 1: FIFO holds `DEPTH` words.
- `level` out $clog2(DEPTH+1): number of words in the FIFO.
- `overflow` out 1: sticky; set when a completed word is dropped; cleared only by reset.
- `parity_err` out 1: one-cycle pulse on a parity mismatch. Tied to 0 when `DESER_PARITY_EN` is undefined.

## Operation
Reset values (`reset_n`=0):
- State IDLE; bit counter 0; shift register 0; FIFO pointers and `level` 0.
- All outputs 0.

Reset mid-word discards the partial word. Reset with the FIFO non-empty discards all queued words.

Receive state machine:
- IDLE:
  - `write_in`=1 → shift in the bit, counter=1, go to RECEIVING.
  - `write_in`=0 → stay in IDLE.
- RECEIVING:
  - Each cycle with `write_in`=1 shifts in one bit and increments the counter.
  - A cycle with `write_in`=0 holds all state. There is no timeout.
  - On the bit that brings the counter to `WIDTH`:
    - If parity is enabled → go to PARITY.
    - Otherwise → push the completed word (the shift register including the current bit), clear the counter, go to IDLE.
- PARITY (only when `DESER_PARITY_EN` is defined):
  - Waits for the next `write_in`=1 cycle.
  - Even parity: XOR of the word and the parity bit must be 0.
  - Match → push the word.
  - Mismatch → drop the word and pulse `parity_err`.
  - In both cases go to IDLE.

Push and pop rules:
- Push: write at the write pointer, then increment it; wrap-around is modulo `DEPTH`.
- Pop: occurs when `ack_in`=1 and `data_ready`=1; increment the read pointer.
- Push and pop in the same cycle: both occur; `level` is unchanged.
- Push with `full`=1 and a simultaneous pop: the push is accepted.
- Push with `full`=1 and no pop: the word is dropped and `overflow` is set. The FIFO contents are unchanged and receiving continues.
- `ack_in` with an empty FIFO: no effect, and no underflow.

## Timing
- Latency: when the final bit (or parity bit) is sampled at edge N, the word is visible on `data_out` and `data_ready`=1 after edge N, provided the FIFO was empty.
- Back-to-back words need no idle cycle. The first bit of the next word may arrive on the cycle after the final bit of the previous word.
- Pop with `ack_in` high at edge M: the next entry (or 0 if the FIFO is now empty) appears after edge M.
- `data_ready` falls after edge M only if `level` was 1.
- Holding `ack_in` high pops one word per cycle.
- `status_out` is registered and high from the cycle after the first bit until the cycle after the word completes.
- `overflow` and `parity_err` are registered and change after the edge that caused them.

## Configuration
- `DESER_PARITY_EN` defined:
  - Each word is followed by one even-parity bit.
  - The PARITY state exists.
  - Words with a mismatch are dropped and flagged on `parity_err`.
- `DESER_PARITY_EN` undefined:
  - Words are exactly `WIDTH` bits.
  - No PARITY state.
  - `parity_err` is constant 0.

## Structure
- Package `deser_pkg`:
  - `state_t` enum (IDLE, RECEIVING, PARITY).
  - Default constants `DESER_WIDTH_DEF`=8 and `DESER_DEPTH_DEF`=4.
- Sub-module `deser_fifo`:
  - Parameters `WIDTH` and `DEPTH`.
  - Ports: push, pop, din, dout, empty, full, level; same clock and reset.
- The top level holds the shift register, counter, state machine, and the parity and overflow logic.

## Test plan
- **Single word, MSB first:** `WIDTH`=8, `MSB_FIRST`=1; serial bits 1,0,1,0,0,1,0,1 → `data_out`=8'hA5 and `data_ready`=1 one cycle after the 8th bit; `ack_in` → `data_ready`=0 and `data_out`=0.
- **Single word, LSB first:** `MSB_FIRST`=0, same bit stream → `data_out`=8'hA5 reversed, i.e. 8'hA5 becomes 8'hA5 bit-reversed = 8'hA5 (the pattern is a palindrome). Repeat with bits 1,1,0,0,0,0,0,0 → 8'h03.
- **Overflow:** `DEPTH`=4; five back-to-back words with no `ack_in` → `full`=1, `level`=4, `overflow`=1; popping returns the first four words in order.
- **Simultaneous push and pop when full:** with the FIFO full, the last bit of a word and `ack_in` in the same cycle → `level` stays 4, no overflow, the new word is the last popped.
- **Reset mid-operation:** `reset_n` low after 3 bits with 2 words queued → all outputs 0; the next 8 bits form a correct word.
- **Parity (`DESER_PARITY_EN`):** word 8'h0F with parity 0 → accepted. Word 8'h0F with parity 1 → `parity_err` pulses for 1 cycle, `level` is unchanged.
